mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single unified memory port of risc_top between instruction fetch (IF) and load/store (LS).
// - Per-requester req/ack handshake; one memory transaction in flight at a time.
// - LS has priority; a starvation guard can be compiled in.
// - Sits between the datapath's fetch and LSU request signals and the memory model.
// PARAMETERS
// - XLEN        64  address and data width.
// - ILEN        32  instruction width returned on if_rdata (mem_rdata[ILEN-1:0]).
// - STARVE_MAX  4   LS grants tolerated while IF waits (guard build only); range 1..2**CNT_W-1.
// - CNT_W       3   width of the starvation counter.
// PORTS
// - clk        in   1       clock; all state updates on the posedge.
// - rst        in   1       synchronous, active-high reset.
// - if_req     in   1       fetch request; held with if_addr stable until if_ack.
// - if_addr    in   XLEN    fetch address.
// - if_ack     out  1       one-cycle completion pulse for IF.
// - if_rdata   out  ILEN    instruction; valid only while if_ack=1.
// - ls_req     in   1       load/store request; held with its fields stable until ls_ack.
// - ls_we      in   1       1=store, 0=load.
// - ls_addr    in   XLEN    data address.
// - ls_wdata   in   XLEN    store data.
// - ls_wstrb   in   XLEN/8  store byte enables.
// - ls_ack     out  1       one-cycle completion pulse for LS.
// - ls_rdata   out  XLEN    load data; valid only while ls_ack=1.
// - mem_req    out  1       memory request; held until mem_ack.
// - mem_we     out  1       write enable to memory.
// - mem_addr   out  XLEN    memory address.
// - mem_wdata  out  XLEN    memory write data.
// - mem_wstrb  out  XLEN/8  memory byte enables; forced to 0 when mem_we=0.
// - mem_ack    in   1       memory done; ignored unless mem_req=1.
// - mem_rdata  in   XLEN    read data, valid with mem_ack.
// BEHAVIOUR
// - States: IDLE, BUSY_IF, BUSY_LS. Reset -> IDLE; all outputs 0; starvation counter 0.
// - IDLE: ls_req=1 -> BUSY_LS; else if_req=1 -> BUSY_IF; else stay. The winner's fields are registered at this edge.
// - BUSY_x: mem_req=1; mem_* are driven from the registered fields, stable for the whole transaction.
// - BUSY_x with mem_ack=1: x_ack=1 combinationally in the same cycle; x_rdata = mem_rdata (truncated to ILEN for IF).
//   Next state is IDLE.
// - Latency: request seen in IDLE at cycle N -> mem_req from N+1 -> x_ack in the mem_ack cycle. Minimum 2 cycles.
// - One idle cycle always separates transactions; back-to-back requests cost mem latency + 1.
// - Requester drops req at the edge ending its ack cycle, so a stale req is never re-granted.
// - Simultaneous if_req and ls_req in IDLE: LS wins (guard build: see CONFIGURATION); IF stays pending, no ack.
// - The request inputs are not re-sampled in BUSY_x; changes to req in BUSY_x have no effect.
// - mem_ack in IDLE is ignored; no ack is produced.
// - rst mid-transaction: -> IDLE next edge; mem_req and acks drop; the in-flight access is abandoned
//   (memory shares rst). Requesters must re-request.
// - if_ack and ls_ack are never both 1; an ack never occurs without a prior grant.
// CONFIGURATION
// - STARVE_GUARD_EN defined:
//   - The counter increments on each LS grant made while if_req=1, saturating at STARVE_MAX.
//   - The counter clears on an IF grant or when if_req=0 in IDLE.
//   - When the counter equals STARVE_MAX, the next IDLE arbitration with if_req=1 grants IF even if ls_req=1.
// - STARVE_GUARD_EN undefined: strict LS priority; counter logic is absent; IF can starve indefinitely.
// TESTING
// - Reset: hold rst 3 cycles while mem_ack toggles -> mem_req, if_ack, ls_ack stay 0; state IDLE.
// - IF only: if_addr=0x100, mem_ack 2 cycles after mem_req, mem_rdata=0x00500093
//   -> mem_addr=0x100, mem_we=0; if_ack pulses once; if_rdata=0x00500093.
// - Store: ls_we=1, ls_addr=0x2000, ls_wdata=0x1D, ls_wstrb=0xFF
//   -> mem_we=1 with the same fields; one ls_ack; if_ack stays 0.
// - Contention: if_req and ls_req both raised at cycle N -> LS is served first (ls_ack);
//   after one IDLE cycle IF is served (if_ack).
// - Starvation (guard build, STARVE_MAX=4): ls_req held high and re-requested continuously, if_req high
//   -> exactly 4 ls_acks, then 1 if_ack, then LS resumes. Without the guard: 0 if_acks over 50 cycles.
// - Reset mid-op: rst asserted in BUSY_LS before mem_ack -> no ls_ack; mem_req=0 the next cycle;
//   a fresh if_req completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle around mem_port_arbiter: IF and LS requester handshakes plus the shared memory port.
// slave = the arbiter's view; master = the requesters and the memory seen together.
interface mem_port_arbiter_if #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
);
  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic              if_ack;
  logic [ILEN-1:0]   if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [XLEN-1:0]   ls_addr;
  logic [XLEN-1:0]   ls_wdata;
  logic [XLEN/8-1:0] ls_wstrb;
  logic              ls_ack;
  logic [XLEN-1:0]   ls_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb, mem_ack, mem_rdata,
    output if_ack, if_rdata, ls_ack, ls_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb, mem_ack, mem_rdata,
    input  if_ack, if_rdata, ls_ack, ls_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (IF) and load/store (LS), LS first.
// Define STARVE_GUARD_EN to force an IF grant after STARVE_MAX LS grants made while IF waits.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | no access in flight; arbitrate and latch the winner's fields
//   BUSY_IF | fetch access on the memory port, waiting for mem_ack
//   BUSY_LS | load/store access on the memory port, waiting for mem_ack
module mem_port_arbiter #(
  parameter int XLEN       = 64,
  parameter int ILEN       = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);
  localparam int SW = XLEN / 8;

  if (STARVE_MAX < 1 || STARVE_MAX > (2**CNT_W) - 1) begin : g_bad_cfg
    $error("mem_port_arbiter: STARVE_MAX does not fit in CNT_W bits");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_LS = 2'd2
  } state_t;

  state_t            state;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [XLEN-1:0]   mem_addr_q;
  logic [XLEN-1:0]   mem_wdata_q;
  logic [SW-1:0]     mem_wstrb_q;

  logic              grant_if;
  logic              grant_ls;
  logic              done;
  logic              if_ack_w;
  logic              ls_ack_w;

`ifdef STARVE_GUARD_EN
  logic [CNT_W-1:0]  starve_cnt;
  logic              starved;

  assign starved  = (starve_cnt == CNT_W'(STARVE_MAX));
  assign grant_if = bus.if_req && (!bus.ls_req || starved);

  // Counts LS grants that overtook a waiting fetch; only meaningful in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!bus.if_req || grant_if) begin
        starve_cnt <= '0;
      end else if (grant_ls && !starved) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end
`else
  assign grant_if = bus.if_req && !bus.ls_req;
`endif

  assign grant_ls = bus.ls_req && !grant_if;

  // An access being abandoned by reset never completes towards the requester.
  assign done     = mem_req_q && bus.mem_ack && !rst;
  assign if_ack_w = done && (state == BUSY_IF);
  assign ls_ack_w = done && (state == BUSY_LS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ls) begin
            state       <= BUSY_LS;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.ls_we;
            mem_addr_q  <= bus.ls_addr;
            mem_wdata_q <= bus.ls_wdata;
            mem_wstrb_q <= bus.ls_we ? bus.ls_wstrb : '0;
          end else if (grant_if) begin
            state       <= BUSY_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end
        end
        BUSY_IF, BUSY_LS: begin
          if (bus.mem_ack) begin
            state     <= IDLE;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;

  assign bus.if_ack    = if_ack_w;
  assign bus.ls_ack    = ls_ack_w;
  assign bus.if_rdata  = if_ack_w ? bus.mem_rdata[ILEN-1:0] : '0;
  assign bus.ls_rdata  = ls_ack_w ? bus.mem_rdata : '0;
endmodule
